hyper_rsp_model: RTL and testbench

//  Synthesizable HyperBus responder (device end of the HyperRAM link). Decodes the 48-bit CA

---
 rtl/hyper_rsp_model_if.sv | 29 ++
 rtl/hyper_rsp_model.sv | 214 +++++++++++++++++++++
 tb/tb_hyper_rsp_model.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hyper_rsp_model_if.sv
// hyper_rsp_model_if: HyperBus pins between controller (master) and responder (slave).
//   dram_ck        controller -> responder  HyperBus clock
//   dram_cs_l      controller -> responder  chip select, active low
//   dram_rst_l     controller -> responder  device reset, active low
//   dram_dq_in     controller -> responder  DQ seen at the responder pad input
//   dram_rwds_in   controller -> responder  RWDS seen at the responder pad input (write mask)
//   dram_dq_out    responder -> controller  DQ driven by the responder
//   dram_dq_oe_l   responder -> controller  DQ output enable, active low
//   dram_rwds_out  responder -> controller  RWDS driven by the responder
//   dram_rwds_oe_l responder -> controller  RWDS output enable, active low
interface hyper_rsp_model_if;
    logic       dram_ck;
    logic       dram_cs_l;
    logic       dram_rst_l;
    logic [7:0] dram_dq_in;
    logic       dram_rwds_in;
    logic [7:0] dram_dq_out;
    logic       dram_dq_oe_l;
    logic       dram_rwds_out;
    logic       dram_rwds_oe_l;
    modport master (
        output dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
        input  dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l
    );
    modport slave (
        input  dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
        output dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l
    );
endinterface

// File: rtl/hyper_rsp_model.sv
// hyper_rsp_model: HyperBus responder model with internal 16-bit RAM and ID/CR registers.
//   clk      in   system clock; dram_ck is oversampled here (each phase >= 2 clk)
//   reset_l  in   asynchronous active-low reset
//   bus      if   hyper_rsp_model_if.slave (dram_ck/cs_l/rst_l/dq/rwds pins)
//   busy     out  high while the responder is not idle
// Optional feature: define HYPER_RSP_REFRESH_EN to force 2x latency on every
// REFRESH_PERIOD-th transaction; undefined ties the refresh request low.
module hyper_rsp_model #(
    parameter int          ADDR_W         = 10,
    parameter int          LATENCY        = 6,
    parameter logic [15:0] ID0_VAL        = 16'h0C81,
    parameter logic [15:0] ID1_VAL        = 16'h0001,
    parameter int          REFRESH_PERIOD = 4
) (
    input  logic             clk,
    input  logic             reset_l,
    hyper_rsp_model_if.slave bus,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, CA, LAT, RD, WR, REG_WR} state_t;
    state_t            state_q, state_d;
    logic              ck_q, ck_d;
    logic [47:0]       ca_q, ca_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d, cr0_q, cr0_d, cr1_q, cr1_d;
    logic [1:0]        wmask_q, wmask_d;
    logic              wr_pend_q, wr_pend_d;
    logic [7:0]        dq_out_q, dq_out_d;
    logic              dq_oe_l_q, dq_oe_l_d, rwds_out_q, rwds_out_d, rwds_oe_l_q, rwds_oe_l_d;
    logic [15:0]       mem [2**ADDR_W];
    logic              rise, fall, lat2x, refresh_hit, unused_bits;
    logic [47:0]       ca_next;
    logic [31:0]       ca_word;
    logic [ADDR_W-1:0] addr_inc;
    logic [15:0]       rd_word;

    assign rise     = bus.dram_ck & ~ck_q;
    assign fall     = ~bus.dram_ck & ck_q;
    assign ca_next  = {ca_q[39:0], bus.dram_dq_in};
    assign ca_word  = {ca_next[44:16], ca_next[2:0]};
    // wrapped bursts stay inside the aligned 16-word block
    assign addr_inc = ca_q[45] ? addr_q + ADDR_W'(1) : {addr_q[ADDR_W-1:4], addr_q[3:0] + 4'd1};
    // register space: word-address bit 11 (CA[24]) picks CR vs ID, bit 0 picks which one
    assign rd_word  = ca_q[46] ? (ca_q[24] ? (ca_q[0] ? cr1_q : cr0_q) : (ca_q[0] ? ID1_VAL : ID0_VAL))
                               : mem[addr_q];
    assign lat2x    = cr0_q[3] | refresh_hit;
    assign unused_bits = ^{ca_q[44:40], ca_word};
    assign busy     = state_q != IDLE;

`ifdef HYPER_RSP_REFRESH_EN
    logic [7:0] tx_cnt_q, tx_cnt_d;
    logic       hit_q, hit_d, cs_start;
    assign cs_start = (state_q == IDLE) & ~bus.dram_cs_l & bus.dram_rst_l;
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        hit_d    = hit_q;
        if (!bus.dram_rst_l) begin
            tx_cnt_d = '0;
            hit_d    = 1'b0;
        end else if (cs_start) begin
            hit_d    = tx_cnt_q == 8'(REFRESH_PERIOD - 1);
            tx_cnt_d = hit_d ? '0 : tx_cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            tx_cnt_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            hit_q    <= hit_d;
        end
    end
    // the new transaction's hit is visible on the same clk it leaves IDLE
    assign refresh_hit = hit_d;
`else
    assign refresh_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ck_d        = bus.dram_ck;
        ca_d        = ca_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wr_pend_d   = 1'b0;
        cr0_d       = cr0_q;
        cr1_d       = cr1_q;
        dq_out_d    = dq_out_q;
        dq_oe_l_d   = dq_oe_l_q;
        rwds_out_d  = rwds_out_q;
        rwds_oe_l_d = rwds_oe_l_q;
        // the RAM takes the word this clk, so step to the next burst address
        if (wr_pend_q) addr_d = addr_inc;
        case (state_q)
            IDLE: if (!bus.dram_cs_l) begin
                state_d     = CA;
                cnt_d       = '0;
                rwds_oe_l_d = 1'b0;
                rwds_out_d  = lat2x;
            end
            CA: begin
                rwds_oe_l_d = 1'b0;
                rwds_out_d  = lat2x;
                if (rise | fall) begin
                    ca_d  = ca_next;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd5) begin
                        addr_d      = ca_word[ADDR_W-1:0];
                        state_d     = (!ca_next[47] && ca_next[46]) ? REG_WR : LAT;
                        cnt_d       = (!ca_next[47] && ca_next[46]) ? 8'd0
                                    : (lat2x ? 8'(2 * LATENCY) : 8'(LATENCY));
                        rwds_oe_l_d = !ca_next[47];
                        rwds_out_d  = 1'b0;
                    end
                end
            end
            // count latency rises; the fall after the last one hands over to data
            LAT: begin
                if (rise && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                if (fall && cnt_q == 8'd0) state_d = ca_q[47] ? RD : WR;
            end
            RD: if (rise | fall) begin
                dq_out_d    = rise ? rd_word[15:8] : rd_word[7:0];
                rwds_out_d  = rise;
                dq_oe_l_d   = 1'b0;
                rwds_oe_l_d = 1'b0;
                if (fall) addr_d = addr_inc;
            end
            WR: begin
                if (rise) begin
                    wdata_d[15:8] = bus.dram_dq_in;
                    wmask_d[1]    = bus.dram_rwds_in;
                end
                if (fall) begin
                    wdata_d[7:0] = bus.dram_dq_in;
                    wmask_d[0]   = bus.dram_rwds_in;
                    wr_pend_d    = 1'b1;
                end
            end
            REG_WR: if ((rise | fall) && cnt_q < 8'd2) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd0) wdata_d[15:8] = bus.dram_dq_in;
                cr0_d = (cnt_q == 8'd1 && ca_q[24] && !ca_q[0]) ? {wdata_q[15:8], bus.dram_dq_in} : cr0_q;
                cr1_d = (cnt_q == 8'd1 && ca_q[24] &&  ca_q[0]) ? {wdata_q[15:8], bus.dram_dq_in} : cr1_q;
            end
            default: ;
        endcase
        if (bus.dram_cs_l) begin
            state_d     = IDLE;
            dq_oe_l_d   = 1'b1;
            rwds_oe_l_d = 1'b1;
        end
        if (!bus.dram_rst_l) begin
            state_d     = IDLE;
            wr_pend_d   = 1'b0;
            cr0_d       = 16'h8F1F;
            cr1_d       = 16'h0001;
            dq_out_d    = '0;
            dq_oe_l_d   = 1'b1;
            rwds_out_d  = 1'b0;
            rwds_oe_l_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            ck_q        <= 1'b0;
            ca_q        <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            wr_pend_q   <= 1'b0;
            cr0_q       <= 16'h8F1F;
            cr1_q       <= 16'h0001;
            dq_out_q    <= '0;
            dq_oe_l_q   <= 1'b1;
            rwds_out_q  <= 1'b0;
            rwds_oe_l_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ck_q        <= ck_d;
            ca_q        <= ca_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            wr_pend_q   <= wr_pend_d;
            cr0_q       <= cr0_d;
            cr1_q       <= cr1_d;
            dq_out_q    <= dq_out_d;
            dq_oe_l_q   <= dq_oe_l_d;
            rwds_out_q  <= rwds_out_d;
            rwds_oe_l_q <= rwds_oe_l_d;
        end
    end

    // RWDS high on a byte masks that byte; the RAM itself is never reset
    always_ff @(posedge clk) begin
        if (wr_pend_q)
            mem[addr_q] <= {wmask_q[1] ? mem[addr_q][15:8] : wdata_q[15:8],
                            wmask_q[0] ? mem[addr_q][7:0]  : wdata_q[7:0]};
    end

    assign bus.dram_dq_out    = dq_out_q;
    assign bus.dram_dq_oe_l   = dq_oe_l_q;
    assign bus.dram_rwds_out  = rwds_out_q;
    assign bus.dram_rwds_oe_l = rwds_oe_l_q;
endmodule

// File: tb/tb_hyper_rsp_model.sv
// tb_hyper_rsp_model: directed controller-side bench for hyper_rsp_model with a byte scoreboard.
module tb_hyper_rsp_model;
    localparam int          ADDR_W  = 10;
    localparam int          LATENCY = 6;
    localparam logic [15:0] ID0     = 16'h0C81;
    localparam logic [15:0] ID1     = 16'h0001;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    logic busy;
    hyper_rsp_model_if bus();

    hyper_rsp_model #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset_l(reset_l), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    int          txn    = 0;
    logic [15:0] model [2**ADDR_W];
    logic [15:0] cr0_m = 16'h8F1F;
    logic [15:0] cr1_m = 16'h0001;
    logic [8:0]  sb [$];
    logic [15:0] wdat [4];
    logic [1:0]  wmsk [4];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flip();
        bus.dram_ck = ~bus.dram_ck;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    endtask

    // one chip-select transaction driven from the controller side
    task automatic xfer(input bit rd, input bit rs, input bit lin, input logic [31:0] addr,
                        input int n, input bit abort);
        logic [47:0]       ca;
        logic              l2;
        int                nlat;
        logic [ADDR_W-1:0] a;
        logic [15:0]       w;
        logic [8:0]        e;
        txn++;
        l2 = cr0_m[3];
`ifdef HYPER_RSP_REFRESH_EN
        if (txn % 4 == 0) l2 = 1'b1;
`endif
        nlat = l2 ? 2 * LATENCY : LATENCY;
        ca = {rd, rs, lin, addr[31:3], 13'd0, addr[2:0]};
        bus.dram_cs_l = 1'b0;
        tick(2);
        check("ca_rwds_oe_l", 16'(bus.dram_rwds_oe_l), 16'd0);
        check("ca_rwds_lat2x", 16'(bus.dram_rwds_out), 16'(l2));
        check("busy_high", 16'(busy), 16'd1);
        for (int i = 0; i < 6; i++) begin
            bus.dram_dq_in = ca[47-8*i -: 8];
            flip();
            tick(4);
        end
        if (!rd && rs) begin
            bus.dram_dq_in = wdat[0][15:8];
            flip();
            tick(4);
            bus.dram_dq_in = wdat[0][7:0];
            flip();
            tick(4);
            if (addr[11]) begin
                if (addr[0]) cr1_m = wdat[0];
                else cr0_m = wdat[0];
            end
        end else begin
            for (int i = 0; i < 2 * nlat; i++) begin
                flip();
                tick(4);
            end
            check("lat_dq_oe_l", 16'(bus.dram_dq_oe_l), 16'd1);
            check("lat_rwds_oe_l", 16'(bus.dram_rwds_oe_l), 16'(!rd));
            a = addr[ADDR_W-1:0];
            for (int k = 0; k < n; k++) begin
                if (rd) begin
                    w = rs ? (addr[11] ? (addr[0] ? cr1_m : cr0_m) : (addr[0] ? ID1 : ID0)) : model[a];
                    sb.push_back({1'b1, w[15:8]});
                    sb.push_back({1'b0, w[7:0]});
                    for (int h = 0; h < 2; h++) begin
                        flip();
                        tick(2);
                        e = sb.pop_front();
                        check("rd_rwds_byte", {7'd0, bus.dram_rwds_out, bus.dram_dq_out}, {7'd0, e});
                        check("rd_dq_oe_l", 16'(bus.dram_dq_oe_l), 16'd0);
                        tick(2);
                    end
                end else begin
                    bus.dram_dq_in   = wdat[k][15:8];
                    bus.dram_rwds_in = wmsk[k][1];
                    flip();
                    tick(4);
                    if (abort) break;
                    bus.dram_dq_in   = wdat[k][7:0];
                    bus.dram_rwds_in = wmsk[k][0];
                    flip();
                    tick(4);
                    model[a] = {wmsk[k][1] ? model[a][15:8] : wdat[k][15:8],
                                wmsk[k][0] ? model[a][7:0]  : wdat[k][7:0]};
                end
                a = lin ? a + ADDR_W'(1) : {a[ADDR_W-1:4], a[3:0] + 4'd1};
            end
        end
        bus.dram_cs_l    = 1'b1;
        bus.dram_rwds_in = 1'b0;
        tick(1);
        check("end_dq_oe_l", 16'(bus.dram_dq_oe_l), 16'd1);
        check("end_rwds_oe_l", 16'(bus.dram_rwds_oe_l), 16'd1);
        check("end_busy", 16'(busy), 16'd0);
        if (bus.dram_ck) flip();
        tick(3);
    endtask

    initial begin
        bus.dram_ck      = 1'b0;
        bus.dram_cs_l    = 1'b1;
        bus.dram_rst_l   = 1'b1;
        bus.dram_dq_in   = 8'd0;
        bus.dram_rwds_in = 1'b0;
        tick(3);
        check("rst_dq_oe_l", 16'(bus.dram_dq_oe_l), 16'd1);
        check("rst_rwds_oe_l", 16'(bus.dram_rwds_oe_l), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_dq_out", 16'(bus.dram_dq_out), 16'd0);
        reset_l = 1'b1;
        tick(2);
        xfer(1'b1, 1'b1, 1'b1, 32'h000, 1, 1'b0);
        wdat[0] = 16'h1234; wdat[1] = 16'h5678; wmsk[0] = 2'b00; wmsk[1] = 2'b00;
        xfer(1'b0, 1'b0, 1'b1, 32'h010, 2, 1'b0);
        xfer(1'b1, 1'b0, 1'b1, 32'h010, 2, 1'b0);
        wdat[0] = 16'h1111;
        xfer(1'b0, 1'b0, 1'b1, 32'h020, 1, 1'b0);
        wdat[0] = 16'hAABB; wmsk[0] = 2'b10;
        xfer(1'b0, 1'b0, 1'b1, 32'h020, 1, 1'b0);
        xfer(1'b1, 1'b0, 1'b1, 32'h020, 1, 1'b0);
        wdat[0] = 16'h8F17; wmsk[0] = 2'b00;
        xfer(1'b0, 1'b1, 1'b1, 32'h800, 1, 1'b0);
        xfer(1'b1, 1'b0, 1'b1, 32'h010, 1, 1'b0);
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 1'b0);
        wdat[0] = 16'h8F1F;
        xfer(1'b0, 1'b1, 1'b1, 32'h800, 1, 1'b0);
        xfer(1'b1, 1'b0, 1'b1, 32'h011, 1, 1'b0);
        wdat[0] = 16'hE01E; wdat[1] = 16'hE01F;
        xfer(1'b0, 1'b0, 1'b1, 32'h01E, 2, 1'b0);
        xfer(1'b1, 1'b0, 1'b0, 32'h01E, 4, 1'b0);
        wdat[0] = 16'hDEAD; wdat[1] = 16'hBEEF;
        xfer(1'b0, 1'b0, 1'b1, 32'h3FF, 2, 1'b0);
        xfer(1'b1, 1'b0, 1'b1, 32'h3FF, 2, 1'b0);
        wdat[0] = 16'h4444;
        xfer(1'b0, 1'b0, 1'b1, 32'h030, 1, 1'b0);
        wdat[0] = 16'h99AA;
        xfer(1'b0, 1'b0, 1'b1, 32'h030, 1, 1'b1);
        xfer(1'b1, 1'b0, 1'b1, 32'h030, 1, 1'b0);
        wdat[0] = 16'h0055;
        xfer(1'b0, 1'b1, 1'b1, 32'h801, 1, 1'b0);
        xfer(1'b1, 1'b1, 1'b1, 32'h801, 1, 1'b0);
        bus.dram_rst_l = 1'b0;
        tick(2);
        bus.dram_rst_l = 1'b1;
        cr0_m = 16'h8F1F;
        cr1_m = 16'h0001;
        txn   = 0;
        tick(1);
        xfer(1'b1, 1'b1, 1'b1, 32'h801, 1, 1'b0);
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 1'b0);
        xfer(1'b1, 1'b1, 1'b1, 32'h001, 1, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
